// File: rtl/dual_helix_pkg.sv
// Shared types for the OBI-to-AXI multiplexer: AXI4 channel structs sized for
// the default four-port configuration, response-routing width and FSM states.
package dual_helix_pkg;

    localparam int unsigned DHS_NUM_PORTS = 4;
    localparam int unsigned DHS_AXI_IDW   = (DHS_NUM_PORTS > 1) ? $clog2(DHS_NUM_PORTS) : 1;
    // Width of the id used to route R/B beats back to an OBI port.
    localparam int unsigned DHS_RSP_ROUTE_W = DHS_AXI_IDW;
    localparam int unsigned DHS_AXI_ADDRW   = 32;
    localparam int unsigned DHS_AXI_DATAW   = 32;
    localparam int unsigned DHS_AXI_STRBW   = DHS_AXI_DATAW / 8;
    localparam int unsigned DHS_AXI_USERW   = 1;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        MUX_IDLE = 2'd0,
        MUX_RD   = 2'd1,
        MUX_WR   = 2'd2
    } mux_state_e;

    typedef struct packed {
        logic [DHS_RSP_ROUTE_W-1:0] id;
        logic [DHS_AXI_ADDRW-1:0]   addr;
        logic [7:0]                 len;
        logic [2:0]                 size;
        logic [1:0]                 burst;
        logic                       lock;
        logic [3:0]                 cache;
        logic [2:0]                 prot;
        logic [3:0]                 qos;
        logic [3:0]                 region;
        logic [5:0]                 atop;
        logic [DHS_AXI_USERW-1:0]   user;
    } dhs_cl_sp_axi_aw_t;

    typedef struct packed {
        logic [DHS_AXI_DATAW-1:0] data;
        logic [DHS_AXI_STRBW-1:0] strb;
        logic                     last;
        logic [DHS_AXI_USERW-1:0] user;
    } dhs_cl_sp_axi_w_t;

    typedef struct packed {
        logic [DHS_RSP_ROUTE_W-1:0] id;
        logic [1:0]                 resp;
        logic [DHS_AXI_USERW-1:0]   user;
    } dhs_cl_sp_axi_b_t;

    typedef struct packed {
        logic [DHS_RSP_ROUTE_W-1:0] id;
        logic [DHS_AXI_ADDRW-1:0]   addr;
        logic [7:0]                 len;
        logic [2:0]                 size;
        logic [1:0]                 burst;
        logic                       lock;
        logic [3:0]                 cache;
        logic [2:0]                 prot;
        logic [3:0]                 qos;
        logic [3:0]                 region;
        logic [DHS_AXI_USERW-1:0]   user;
    } dhs_cl_sp_axi_ar_t;

    typedef struct packed {
        logic [DHS_RSP_ROUTE_W-1:0] id;
        logic [DHS_AXI_DATAW-1:0]   data;
        logic [1:0]                 resp;
        logic                       last;
        logic [DHS_AXI_USERW-1:0]   user;
    } dhs_cl_sp_axi_r_t;

    // Handshake rule on every channel: a beat transfers in the cycle where
    // valid and ready are both high; valid never waits on ready.
    typedef struct packed {
        dhs_cl_sp_axi_aw_t aw;
        logic              aw_valid;
        dhs_cl_sp_axi_w_t  w;
        logic              w_valid;
        logic              b_ready;
        dhs_cl_sp_axi_ar_t ar;
        logic              ar_valid;
        logic              r_ready;
    } dhs_cl_sp_axi_req_t;

    typedef struct packed {
        logic              aw_ready;
        logic              ar_ready;
        logic              w_ready;
        logic              b_valid;
        dhs_cl_sp_axi_b_t  b;
        logic              r_valid;
        dhs_cl_sp_axi_r_t  r;
    } dhs_cl_sp_axi_resp_t;

endpackage

// File: rtl/rr_arb_pick.sv
// Round-robin pick: first requester at or after ptr_i (wrapping), returned
// both as a one-hot grant and as an index.
module rr_arb_pick #(
    parameter int unsigned N    = 4,
    parameter int unsigned IDXW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [IDXW-1:0] ptr_i,
    output logic [N-1:0]    gnt_o,
    output logic [IDXW-1:0] idx_o,
    output logic            valid_o
);

    logic [IDXW-1:0] cand;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = IDXW'((32'(ptr_i) + k) % N);
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/obi_mux_2_axi.sv
// Multiplexes NUM_PORTS OBI slave ports onto one AXI4 master, one single-beat
// command at a time, routing R/B responses back to the issuing port by AXI id.
module obi_mux_2_axi
    import dual_helix_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned OBI_ADDRW = 32,
    parameter int unsigned OBI_DATAW = 32,
    parameter int unsigned OBI_STRBW = OBI_DATAW / 8,
    parameter int unsigned MAX_OUTST = 4,
    parameter type axi_req_t  = dhs_cl_sp_axi_req_t,
    parameter type axi_resp_t = dhs_cl_sp_axi_resp_t
) (
    input  logic                                 clk_i,
    input  logic                                 srst_i,
    input  logic [NUM_PORTS-1:0][OBI_ADDRW-1:0]  addr_i,
    input  logic [NUM_PORTS-1:0]                 we_i,
    input  logic [NUM_PORTS-1:0][OBI_DATAW-1:0]  wdata_i,
    input  logic [NUM_PORTS-1:0][OBI_STRBW-1:0]  be_i,
    input  logic [NUM_PORTS-1:0]                 req_i,
    output logic [NUM_PORTS-1:0]                 gnt_o,
    output logic [NUM_PORTS-1:0]                 rvalid_o,
    output logic [NUM_PORTS-1:0][OBI_DATAW-1:0]  rdata_o,
    output logic [NUM_PORTS-1:0]                 err_o,
    output axi_req_t                             axi_req_o,
    input  axi_resp_t                            axi_resp_i,
    output logic                                 unexp_rsp_o
);

    localparam int unsigned IDW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned CNTW = $clog2(MAX_OUTST + 1);

    typedef struct packed {
        logic [OBI_ADDRW-1:0] addr;
        logic                 we;
        logic [OBI_DATAW-1:0] wdata;
        logic [OBI_STRBW-1:0] be;
        logic [IDW-1:0]       id;
    } cmd_t;

    mux_state_e                           state_q, state_d;
    logic [IDW-1:0]                       ptr_q, ptr_d;
    cmd_t                                 cmd_q, cmd_d;
    logic [NUM_PORTS-1:0][CNTW-1:0]       cnt_q, cnt_d;
    logic [NUM_PORTS-1:0]                 dir_q, dir_d;
    logic                                 aw_done_q, aw_done_d;
    logic                                 w_done_q, w_done_d;
    logic                                 unexp_q, unexp_d;
    logic [NUM_PORTS-1:0]                 rvalid_q, rvalid_d;
    logic [NUM_PORTS-1:0][OBI_DATAW-1:0]  rdata_q, rdata_d;
    logic [NUM_PORTS-1:0]                 err_q, err_d;

    logic [NUM_PORTS-1:0] elig, arb_req, arb_gnt, r_hit, b_hit;
    logic [IDW-1:0]       arb_idx;
    logic                 arb_valid, aw_fire, w_fire;
    logic [31:0]          r_id, b_id;
    logic                 unused_bits;

    // A port with commands in flight may only add more of the same direction,
    // so its R and B responses can never collide.
    always_comb begin
        elig = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            elig[p] = req_i[p] && (cnt_q[p] < CNTW'(MAX_OUTST)) &&
                      ((cnt_q[p] == '0) || (we_i[p] == dir_q[p]));
        end
        arb_req = (state_q == MUX_IDLE && !srst_i) ? elig : '0;
    end

    rr_arb_pick #(
        .N    (NUM_PORTS),
        .IDXW (IDW)
    ) u_arb (
        .req_i   (arb_req),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    assign gnt_o = arb_gnt;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cmd_d     = cmd_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        aw_fire   = 1'b0;
        w_fire    = 1'b0;

        axi_req_o          = '0;
        axi_req_o.r_ready  = 1'b1;
        axi_req_o.b_ready  = 1'b1;
        axi_req_o.aw.id    = cmd_q.id;
        axi_req_o.aw.addr  = cmd_q.addr;
        axi_req_o.aw.size  = 3'($clog2(OBI_STRBW));
        axi_req_o.aw.burst = AXI_BURST_INCR;
        axi_req_o.w.data   = cmd_q.wdata;
        axi_req_o.w.strb   = cmd_q.be;
        axi_req_o.w.last   = 1'b1;
        axi_req_o.ar.id    = cmd_q.id;
        axi_req_o.ar.addr  = cmd_q.addr;
        axi_req_o.ar.size  = 3'($clog2(OBI_STRBW));
        axi_req_o.ar.burst = AXI_BURST_INCR;

        unique case (state_q)
            MUX_IDLE: begin
                if (arb_valid) begin
                    cmd_d.addr  = addr_i[arb_idx];
                    cmd_d.we    = we_i[arb_idx];
                    cmd_d.wdata = wdata_i[arb_idx];
                    cmd_d.be    = be_i[arb_idx];
                    cmd_d.id    = arb_idx;
                    ptr_d       = (arb_idx == IDW'(NUM_PORTS - 1)) ? '0 : arb_idx + IDW'(1);
                    state_d     = we_i[arb_idx] ? MUX_WR : MUX_RD;
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                end
            end
            MUX_RD: begin
                axi_req_o.ar_valid = 1'b1;
                if (axi_resp_i.ar_ready) state_d = MUX_IDLE;
            end
            MUX_WR: begin
                axi_req_o.aw_valid = !aw_done_q;
                axi_req_o.w_valid  = !w_done_q;
                aw_fire = !aw_done_q && axi_resp_i.aw_ready;
                w_fire  = !w_done_q && axi_resp_i.w_ready;
                if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
                    state_d   = MUX_IDLE;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end else begin
                    aw_done_d = aw_done_q || aw_fire;
                    w_done_d  = w_done_q || w_fire;
                end
            end
            default: state_d = MUX_IDLE;
        endcase
    end

    // A beat is accepted only if its id names a port that is still owed a
    // response; anything else is dropped and flagged.
    always_comb begin
        rvalid_d = '0;
        rdata_d  = rdata_q;
        err_d    = err_q;
        unexp_d  = unexp_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        r_hit    = '0;
        b_hit    = '0;
        r_id     = 32'(axi_resp_i.r.id);
        b_id     = 32'(axi_resp_i.b.id);
        for (int p = 0; p < NUM_PORTS; p++) begin
            r_hit[p] = axi_resp_i.r_valid && (r_id == 32'(p)) && (cnt_q[p] != '0);
            b_hit[p] = axi_resp_i.b_valid && (b_id == 32'(p)) && (cnt_q[p] != '0);
            if (r_hit[p]) begin
                rvalid_d[p] = 1'b1;
                rdata_d[p]  = axi_resp_i.r.data;
                err_d[p]    = axi_resp_i.r.resp[1];
            end else if (b_hit[p]) begin
                rvalid_d[p] = 1'b1;
                rdata_d[p]  = '0;
                err_d[p]    = axi_resp_i.b.resp[1];
            end
            if (arb_gnt[p]) begin
                if (cnt_q[p] == '0) dir_d[p] = we_i[p];
                if (!(r_hit[p] || b_hit[p])) cnt_d[p] = cnt_q[p] + CNTW'(1);
            end else if (r_hit[p] || b_hit[p]) begin
                cnt_d[p] = cnt_q[p] - CNTW'(1);
            end
        end
        if ((axi_resp_i.r_valid && !(|r_hit)) || (axi_resp_i.b_valid && !(|b_hit))) begin
            unexp_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q   <= MUX_IDLE;
            ptr_q     <= '0;
            cmd_q     <= '0;
            cnt_q     <= '0;
            dir_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            unexp_q   <= 1'b0;
            rvalid_q  <= '0;
            rdata_q   <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cmd_q     <= cmd_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            unexp_q   <= unexp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    assign rvalid_o    = rvalid_q;
    assign rdata_o     = rdata_q;
    assign err_o       = err_q;
    assign unexp_rsp_o = unexp_q;

    assign unused_bits = ^{cmd_q.we, axi_resp_i.r.last, axi_resp_i.r.user,
                           axi_resp_i.r.resp[0], axi_resp_i.b.resp[0], axi_resp_i.b.user};

endmodule

// File: tb/tb_obi_mux_2_axi.sv
// Directed bench for obi_mux_2_axi: a table of single transactions followed by
// hand-written multi-cycle sequences for arbitration, throttling and reset.
module tb_obi_mux_2_axi;
    import dual_helix_pkg::*;

    localparam int NP = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;

    logic                   clk = 1'b0;
    logic                   srst;
    logic [NP-1:0][AW-1:0]  addr;
    logic [NP-1:0]          we;
    logic [NP-1:0][DW-1:0]  wdata;
    logic [NP-1:0][SW-1:0]  be;
    logic [NP-1:0]          req;
    logic [NP-1:0]          gnt;
    logic [NP-1:0]          rvalid;
    logic [NP-1:0][DW-1:0]  rdata;
    logic [NP-1:0]          err;
    dhs_cl_sp_axi_req_t     axi_req;
    dhs_cl_sp_axi_resp_t    axi_resp;
    logic                   unexp;

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q[$];

    typedef struct {
        int          port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rsp_data;
        logic [1:0]  rsp_resp;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    obi_mux_2_axi #(
        .NUM_PORTS (NP),
        .OBI_ADDRW (AW),
        .OBI_DATAW (DW),
        .OBI_STRBW (SW),
        .MAX_OUTST (4)
    ) dut (
        .clk_i       (clk),
        .srst_i      (srst),
        .addr_i      (addr),
        .we_i        (we),
        .wdata_i     (wdata),
        .be_i        (be),
        .req_i       (req),
        .gnt_o       (gnt),
        .rvalid_o    (rvalid),
        .rdata_o     (rdata),
        .err_o       (err),
        .axi_req_o   (axi_req),
        .axi_resp_i  (axi_resp),
        .unexp_rsp_o (unexp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 2 later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        srst = 1'b1;
        cyc();
        cyc();
        srst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int n);
        string tag;
        tag = $sformatf("v%0d", n);
        req[v.port]   = 1'b1;
        we[v.port]    = v.we;
        addr[v.port]  = v.addr;
        wdata[v.port] = v.wdata;
        be[v.port]    = v.be;
        settle();
        chk({tag, "_gnt"}, 64'(gnt), 64'(1) << v.port);
        cyc();
        req[v.port] = 1'b0;
        if (v.we) begin
            axi_resp.aw_ready = 1'b1;
            axi_resp.w_ready  = 1'b1;
        end else begin
            axi_resp.ar_ready = 1'b1;
        end
        settle();
        chk({tag, "_gnt_one_cycle"}, 64'(gnt), 64'(0));
        if (v.we) begin
            chk({tag, "_aw_valid"}, 64'(axi_req.aw_valid), 64'(1));
            chk({tag, "_w_valid"},  64'(axi_req.w_valid), 64'(1));
            chk({tag, "_aw_id"},    64'(axi_req.aw.id), 64'(v.port));
            chk({tag, "_aw_addr"},  64'(axi_req.aw.addr), 64'(v.addr));
            chk({tag, "_aw_size"},  64'(axi_req.aw.size), 64'(2));
            chk({tag, "_aw_burst"}, 64'(axi_req.aw.burst), 64'(1));
            chk({tag, "_w_data"},   64'(axi_req.w.data), 64'(v.wdata));
            chk({tag, "_w_strb"},   64'(axi_req.w.strb), 64'(v.be));
            chk({tag, "_w_last"},   64'(axi_req.w.last), 64'(1));
        end else begin
            chk({tag, "_ar_valid"}, 64'(axi_req.ar_valid), 64'(1));
            chk({tag, "_ar_id"},    64'(axi_req.ar.id), 64'(v.port));
            chk({tag, "_ar_addr"},  64'(axi_req.ar.addr), 64'(v.addr));
            chk({tag, "_ar_len"},   64'(axi_req.ar.len), 64'(0));
            chk({tag, "_ar_size"},  64'(axi_req.ar.size), 64'(2));
        end
        cyc();
        axi_resp.aw_ready = 1'b0;
        axi_resp.w_ready  = 1'b0;
        axi_resp.ar_ready = 1'b0;
        settle();
        chk({tag, "_valids_drop"},
            64'({axi_req.ar_valid, axi_req.aw_valid, axi_req.w_valid}), 64'(0));
        if (v.we) begin
            axi_resp.b_valid = 1'b1;
            axi_resp.b.id    = 2'(v.port);
            axi_resp.b.resp  = v.rsp_resp;
        end else begin
            axi_resp.r_valid = 1'b1;
            axi_resp.r.id    = 2'(v.port);
            axi_resp.r.data  = v.rsp_data;
            axi_resp.r.resp  = v.rsp_resp;
        end
        cyc();
        axi_resp.b_valid = 1'b0;
        axi_resp.r_valid = 1'b0;
        settle();
        chk({tag, "_rvalid"}, 64'(rvalid), 64'(1) << v.port);
        chk({tag, "_rdata"},  64'(rdata[v.port]), 64'(v.exp_rdata));
        chk({tag, "_err"},    64'(err[v.port]), 64'(v.exp_err));
    endtask

    initial begin
        logic [1:0] e;

        vecs[0] = '{2, 1'b0, 32'h4000_0010, 32'h0000_0000, 4'hF, 32'hDEAD_BEEF, AXI_RESP_OKAY,   32'hDEAD_BEEF, 1'b0};
        vecs[1] = '{0, 1'b0, 32'h0000_1000, 32'h0000_0000, 4'hF, 32'h1234_5678, AXI_RESP_SLVERR, 32'h1234_5678, 1'b1};
        vecs[2] = '{1, 1'b1, 32'h8000_0004, 32'hA5A5_5A5A, 4'h3, 32'h0000_0000, AXI_RESP_OKAY,   32'h0000_0000, 1'b0};
        vecs[3] = '{3, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 4'hF, 32'h0000_0000, AXI_RESP_DECERR, 32'h0000_0000, 1'b1};
        vecs[4] = '{3, 1'b0, 32'h0000_0040, 32'h0000_0000, 4'hF, 32'h7777_0001, AXI_RESP_EXOKAY, 32'h7777_0001, 1'b0};
        vecs[5] = '{0, 1'b1, 32'h1000_0000, 32'h1357_9BDF, 4'hC, 32'h0000_0000, AXI_RESP_EXOKAY, 32'h0000_0000, 1'b0};

        req = '0; we = '0; addr = '0; wdata = '0; be = '0; axi_resp = '0; srst = 1'b1;
        #1;
        do_reset();
        settle();
        chk("rst_gnt", 64'(gnt), 64'(0));
        chk("rst_rvalid", 64'(rvalid), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_unexp", 64'(unexp), 64'(0));
        chk("rst_axi_valids", 64'({axi_req.ar_valid, axi_req.aw_valid, axi_req.w_valid}), 64'(0));
        chk("tied_readies", 64'({axi_req.r_ready, axi_req.b_ready}), 64'(3));
        for (int p = 0; p < NP; p++) chk($sformatf("rst_rdata%0d", p), 64'(rdata[p]), 64'(0));

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // All four ports stream reads: grants 0,1,2,3,0 on every second cycle.
        do_reset();
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        req = '1; we = '0; axi_resp.ar_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            settle();
            if (c % 2 == 0) begin
                e = exp_q.pop_front();
                chk($sformatf("rr_gnt_c%0d", c), 64'(gnt), 64'(1) << e);
            end else begin
                chk($sformatf("rr_gap_c%0d", c), 64'(gnt), 64'(0));
            end
            cyc();
        end
        req = '0; axi_resp.ar_ready = 1'b0;
        chk("rr_queue_drained", 64'(exp_q.size()), 64'(0));
        do_reset();

        // Write on port 1, w_ready three cycles after aw_ready; port 0 waits.
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h0000_2000; wdata[1] = 32'h0BAD_CAFE; be[1] = 4'hF;
        settle();
        chk("wr_gnt", 64'(gnt), 64'(2));
        cyc();
        req[1] = 1'b0;
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h0000_0100;
        axi_resp.aw_ready = 1'b1;
        settle();
        chk("wr_t1_valids", 64'({axi_req.aw_valid, axi_req.w_valid}), 64'(3));
        chk("wr_t1_gnt", 64'(gnt), 64'(0));
        cyc();
        axi_resp.aw_ready = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            if (c == 4) axi_resp.w_ready = 1'b1;
            settle();
            chk($sformatf("wr_t%0d_valids", c), 64'({axi_req.aw_valid, axi_req.w_valid}), 64'(1));
            chk($sformatf("wr_t%0d_gnt", c), 64'(gnt), 64'(0));
            cyc();
        end
        axi_resp.w_ready = 1'b0;
        settle();
        chk("wr_done_valids", 64'({axi_req.aw_valid, axi_req.w_valid}), 64'(0));
        chk("wr_next_gnt", 64'(gnt), 64'(1));
        cyc();
        req[0] = 1'b0;
        axi_resp.ar_ready = 1'b1;
        settle();
        chk("rd0_ar_id", 64'({axi_req.ar_valid, axi_req.ar.id}), 64'({1'b1, 2'd0}));
        cyc();
        axi_resp.ar_ready = 1'b0;
        axi_resp.b_valid = 1'b1; axi_resp.b.id = 2'd1; axi_resp.b.resp = AXI_RESP_SLVERR;
        axi_resp.r_valid = 1'b1; axi_resp.r.id = 2'd0; axi_resp.r.data = 32'hCAFE_F00D; axi_resp.r.resp = AXI_RESP_OKAY;
        cyc();
        axi_resp.b_valid = 1'b0; axi_resp.r_valid = 1'b0;
        settle();
        chk("dual_rvalid", 64'(rvalid), 64'(3));
        chk("dual_err", 64'(err[1:0]), 64'(2));
        chk("dual_rdata1", 64'(rdata[1]), 64'(0));
        chk("dual_rdata0", 64'(rdata[0]), 64'(32'hCAFE_F00D));

        // Port 0: four reads outstanding blocks the fifth until one R returns.
        do_reset();
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h2000_0000; axi_resp.ar_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c == 11) begin
                axi_resp.r_valid = 1'b1; axi_resp.r.id = 2'd0;
                axi_resp.r.data = 32'h0BAD_F00D; axi_resp.r.resp = AXI_RESP_OKAY;
            end
            settle();
            chk($sformatf("outst_gnt_c%0d", c), 64'(gnt), (c < 8 && c % 2 == 0) ? 64'(1) : 64'(0));
            cyc();
        end
        axi_resp.r_valid = 1'b0;
        settle();
        chk("outst_regrant", 64'(gnt), 64'(1));
        chk("outst_rvalid", 64'(rvalid), 64'(1));
        cyc();
        req[0] = 1'b0;
        cyc();
        axi_resp.ar_ready = 1'b0;
        do_reset();

        // Port 3: read in flight blocks a write until the R comes back.
        req[3] = 1'b1; we[3] = 1'b0; addr[3] = 32'h3000_0000;
        settle();
        chk("dir_rd_gnt", 64'(gnt), 64'(8));
        cyc();
        we[3] = 1'b1; wdata[3] = 32'h5555_AAAA; be[3] = 4'hF; axi_resp.ar_ready = 1'b1;
        settle();
        chk("dir_ar_valid", 64'(axi_req.ar_valid), 64'(1));
        cyc();
        axi_resp.ar_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) begin
                axi_resp.r_valid = 1'b1; axi_resp.r.id = 2'd3;
                axi_resp.r.data = 32'h0000_0033; axi_resp.r.resp = AXI_RESP_OKAY;
            end
            settle();
            chk($sformatf("dir_block_c%0d", c), 64'(gnt), 64'(0));
            cyc();
        end
        axi_resp.r_valid = 1'b0;
        settle();
        chk("dir_wr_gnt", 64'(gnt), 64'(8));
        chk("dir_r_delivered", 64'(rvalid), 64'(8));
        cyc();
        req[3] = 1'b0; axi_resp.aw_ready = 1'b1; axi_resp.w_ready = 1'b1;
        settle();
        chk("dir_aw_id", 64'({axi_req.aw_valid, axi_req.aw.id}), 64'({1'b1, 2'd3}));
        cyc();
        axi_resp.aw_ready = 1'b0; axi_resp.w_ready = 1'b0;
        axi_resp.b_valid = 1'b1; axi_resp.b.id = 2'd3; axi_resp.b.resp = AXI_RESP_OKAY;
        cyc();
        axi_resp.b_valid = 1'b0;
        settle();
        chk("dir_b_rvalid", 64'(rvalid), 64'(8));
        chk("dir_b_err", 64'(err[3]), 64'(0));

        // Reset while in WR with the address already accepted.
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h0000_5000; wdata[1] = 32'h1111_2222;
        settle();
        chk("rst_wr_gnt", 64'(gnt), 64'(2));
        cyc();
        req[1] = 1'b0; axi_resp.aw_ready = 1'b1;
        cyc();
        axi_resp.aw_ready = 1'b0;
        settle();
        chk("rst_wr_aw_done", 64'({axi_req.aw_valid, axi_req.w_valid}), 64'(1));
        srst = 1'b1;
        cyc();
        srst = 1'b0;
        settle();
        chk("rst_mid_valids", 64'({axi_req.ar_valid, axi_req.aw_valid, axi_req.w_valid}), 64'(0));
        chk("rst_mid_gnt", 64'(gnt), 64'(0));
        chk("rst_mid_rvalid", 64'(rvalid), 64'(0));
        chk("rst_mid_unexp", 64'(unexp), 64'(0));
        axi_resp.b_valid = 1'b1; axi_resp.b.id = 2'd1; axi_resp.b.resp = AXI_RESP_OKAY;
        cyc();
        axi_resp.b_valid = 1'b0;
        settle();
        chk("stale_b_unexp", 64'(unexp), 64'(1));
        chk("stale_b_no_rvalid", 64'(rvalid), 64'(0));
        cyc();
        settle();
        chk("unexp_sticky", 64'(unexp), 64'(1));
        do_reset();
        settle();
        chk("unexp_cleared", 64'(unexp), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d, errors %0d", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/obi_mux_2_axi.md
OBI_MUX_2_AXI -- requirements
Module: obi_mux_2_axi

Interface
REQ-001 The module SHALL have these parameters, one per line: name, default, meaning:
- NUM_PORTS, 4, number of OBI slave ports (1..16).
- OBI_ADDRW, 32, address width.
- OBI_DATAW, 32, data width (32 or 64).
- OBI_STRBW, OBI_DATAW/8, byte-enable width.
- MAX_OUTST, 4, maximum outstanding transactions per port (1..15).
- axi_req_t and axi_resp_t, dual_helix_pkg types, AXI4 master request and response structs.
REQ-002 The module SHALL have these ports, one per line: name, direction, width, meaning:
- clk_i, in, 1, single clock.
- srst_i, in, 1, synchronous active-high reset.
- addr_i, in, [NUM_PORTS][OBI_ADDRW], OBI address.
- we_i, in, [NUM_PORTS], write enable.
- wdata_i, in, [NUM_PORTS][OBI_DATAW], write data.
- be_i, in, [NUM_PORTS][OBI_STRBW], byte enables.
- req_i, in, [NUM_PORTS], OBI request.
- gnt_o, out, [NUM_PORTS], OBI grant.
- rvalid_o, out, [NUM_PORTS], OBI response valid.
- rdata_o, out, [NUM_PORTS][OBI_DATAW], read data.
- err_o, out, [NUM_PORTS], response error, qualified by rvalid_o.
- axi_req_o, out, axi_req_t, AXI master request.
- axi_resp_i, in, axi_resp_t, AXI master response.
- unexp_rsp_o, out, 1, sticky flag for an unexpected response.

Function
REQ-003 Port p SHALL be eligible when req_i[p]=1, outst_cnt[p]<MAX_OUTST, and either outst_cnt[p]=0 or we_i[p] equals the port's pending direction flag.
REQ-004 Arbitration SHALL be round-robin, and only in state IDLE: the pointer starts at port 0, and after a grant to p the search starts at p+1 mod NUM_PORTS.
REQ-005 Granting SHALL take one cycle: gnt_o[p] high for exactly that IDLE cycle; the port's addr/we/wdata/be, with id=p, SHALL be latched into a command register.
REQ-006 The FSM SHALL have three states:
- IDLE: go to RD on a read grant, WR on a write grant, else stay.
- RD: drive ar_valid; go to IDLE on ar_ready.
- WR: drive aw_valid and w_valid independently, using aw_done/w_done flags; go to IDLE in the cycle both handshakes have completed, whether same-cycle or either order.
REQ-007 AXI fields SHALL be:
- len=0, size=log2(OBI_STRBW), burst=INCR, id=port index.
- w_last=1, w_strb=be.
- cache, prot, qos, region, atop and user all 0.
REQ-008 Sustained throughput SHALL be one transaction per 2 cycles; gnt_o SHALL be all-zero outside IDLE.
REQ-009 r_ready and b_ready SHALL be tied to 1.
- An R beat with id=p SHALL produce rvalid_o[p]=1 on the next cycle, with registered rdata_o[p]=r.data and err_o[p]=(r.resp[1]).
- A B beat with id=p SHALL produce rvalid_o[p]=1, rdata_o[p]=0, err_o[p]=(b.resp[1]).
REQ-010 R and B beats for different ports in the same cycle SHALL both be delivered in the same cycle. The direction rule guarantees they never target the same port.
REQ-011 outst_cnt[p] SHALL behave as follows:
- increment on grant; decrement on response.
- unchanged when grant and response coincide.
- width $clog2(MAX_OUTST+1).
- the direction flag is set on the grant taken at outst_cnt[p]=0.
REQ-012 A response for port p with outst_cnt[p]=0, or with id>=NUM_PORTS, SHALL be dropped and SHALL set unexp_rsp_o, which stays set until reset.
REQ-013 A port SHALL be able to hold req_i while outst_cnt[p]=MAX_OUTST without being granted, and SHALL be granted in the first IDLE cycle after its count drops.

Reset
REQ-014 When srst_i=1 at a clk_i edge, the following SHALL be cleared:
- FSM to IDLE, RR pointer to 0, all counters and direction flags.
- aw_done, w_done, unexp_rsp_o.
- every output to 0, including all axi_req_o valids.
REQ-015 Reset mid-transaction SHALL abandon in-flight commands. Responses that arrive later SHALL be handled per REQ-012.

Structure
REQ-016 The response-routing width constant and the AXI request/response typedefs with ID width $clog2(NUM_PORTS) (default dhs_cl_sp_axi_req_t / dhs_cl_sp_axi_resp_t) SHALL live in dual_helix_pkg.
REQ-017 Round-robin selection SHALL be the sub-module rr_arb_pick (req vector, pointer in; one-hot grant and index out). Everything else SHALL be flat.

Verification
REQ-018 The bench SHALL cover these scenarios:
- Read, port 2, addr 0x4000_0010, ar_ready=1, R data 0xDEAD_BEEF id 2 resp OKAY: gnt_o[2] 1 cycle, ar.id=2, rvalid_o[2] with 0xDEAD_BEEF, err_o=0.
- Ports 0-3 request continuously, all slaves ready: grants 0,1,2,3,0 on every second cycle.
- Write, port 1, with w_ready 3 cycles after aw_ready: FSM stays WR until both done. Later b.resp=SLVERR produces rvalid_o[1]=1, err_o[1]=1.
- Port 0 issues 4 reads with no R responses: 5th request not granted. Return one R: grant in next IDLE.
- Port 3 with a read outstanding requests a write: blocked until the R returns, then granted.
- srst_i in WR with aw_done=1: outputs 0. Stale B id=1 afterwards: unexp_rsp_o=1, no rvalid_o.
